// File: rtl/mipsfpga_io_debounce.sv
// -----------------------------------------------------------------------------
// mipsfpga_io_debounce
//
// Purpose:
//   Debounces the board's 18 slide switches and 5 pushbuttons before they reach
//   the GPIO read ports. Each raw pin is first brought into the HCLK domain by
//   a two-flop synchronizer. A per-bit counter then measures how long the
//   synchronized value has disagreed with the debounced value. The debounced
//   value only updates after DB_CYCLES consecutive disagreeing cycles.
//   Edge pulses are produced for the pushbuttons (press/release) and a single
//   change pulse for the switch bank.
//
// Parameters:
//   DB_CYCLES  consecutive mismatching cycles needed to accept a new value
//              (legal range 2..65535)
//   CNT_W      per-bit counter width; must be able to hold DB_CYCLES-1
//
// Ports:
//   HCLK        in   1   clock, all state updates on the rising edge
//   HRESET      in   1   asynchronous active-high reset
//   SW_RAW      in  18   raw slide-switch pins (asynchronous)
//   PB_RAW      in   5   raw pushbutton pins (asynchronous, 1 = pressed)
//   IO_Switch   out 18   debounced switches
//   IO_PB       out  5   debounced pushbuttons
//   PB_PRESS    out  5   one-cycle pulse on a debounced 0->1 of IO_PB
//   PB_RELEASE  out  5   one-cycle pulse on a debounced 1->0 of IO_PB
//   SW_CHANGE   out  1   one-cycle pulse when any IO_Switch bit updates
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mipsfpga_io_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [17:0] SW_RAW,
    input  logic [4:0]  PB_RAW,
    output logic [17:0] IO_Switch,
    output logic [4:0]  IO_PB,
    output logic [4:0]  PB_PRESS,
    output logic [4:0]  PB_RELEASE,
    output logic        SW_CHANGE
);

    // Switches occupy bits [17:0], pushbuttons bits [22:18] of the combined
    // per-bit vectors below.
    localparam int NB    = 23;
    localparam int SW_W  = 18;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [NB-1:0]    w_raw;
    logic [NB-1:0]    r_sync1;
    logic [NB-1:0]    r_sync2;
    logic [NB-1:0]    r_state;
    logic [NB-1:0]    w_state_nxt;
    logic [NB-1:0]    w_upd;
    logic [CNT_W-1:0] r_cnt     [NB];
    logic [CNT_W-1:0] w_cnt_nxt [NB];

    logic [4:0]       w_pb_press;
    logic [4:0]       w_pb_release;
    logic             w_sw_change;
    logic [4:0]       r_pb_press;
    logic [4:0]       r_pb_release;
    logic             r_sw_change;

    assign w_raw = {PB_RAW, SW_RAW};

    // Two-flop synchronizer for every raw input bit.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_sync1 <= {NB{1'b0}};
            r_sync2 <= {NB{1'b0}};
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce decision: count consecutive mismatches, accept the new
    // value on the cycle the count reaches its terminal value. Any agreement
    // (including a glitch ending early) clears the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_upd       = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            w_cnt_nxt[i] = CNT_ZERO;
            if (r_sync2[i] != r_state[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_upd[i]       = 1'b1;
                    w_state_nxt[i] = r_sync2[i];
                    w_cnt_nxt[i]   = CNT_ZERO;
                end else begin
                    w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
                end
            end else begin
                w_cnt_nxt[i] = CNT_ZERO;
            end
        end
    end

    // Edge pulses are computed from the update about to be committed, so the
    // registered pulse lines up with the edge on which the debounced bit moves.
    // The new value of an updating bit is its sync2 value, which makes press
    // and release mutually exclusive per bit.
    always_comb begin
        w_pb_press   = w_upd[NB-1:SW_W] &  r_sync2[NB-1:SW_W];
        w_pb_release = w_upd[NB-1:SW_W] & ~r_sync2[NB-1:SW_W];
        w_sw_change  = |w_upd[SW_W-1:0];
    end

    // Debounce counters and debounced state.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= {NB{1'b0}};
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
        end else begin
            r_state <= w_state_nxt;
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Registered edge pulses.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_pb_press   <= 5'b00000;
            r_pb_release <= 5'b00000;
            r_sw_change  <= 1'b0;
        end else begin
            r_pb_press   <= w_pb_press;
            r_pb_release <= w_pb_release;
            r_sw_change  <= w_sw_change;
        end
    end

    assign IO_Switch  = r_state[SW_W-1:0];
    assign IO_PB      = r_state[NB-1:SW_W];
    assign PB_PRESS   = r_pb_press;
    assign PB_RELEASE = r_pb_release;
    assign SW_CHANGE  = r_sw_change;

endmodule

// File: tb/tb_mipsfpga_io_debounce.sv
// -----------------------------------------------------------------------------
// tb_mipsfpga_io_debounce
//
// Directed bench for mipsfpga_io_debounce with DB_CYCLES=4. Each step drives
// the raw inputs on a falling edge, pushes the expected output word for every
// following rising edge into a scoreboard queue, then advances the clock and
// pops/compares one entry per edge (sampled 1 time unit after the edge).
// Output word layout: {IO_Switch, IO_PB, PB_PRESS, PB_RELEASE, SW_CHANGE}.
// -----------------------------------------------------------------------------
module tb_mipsfpga_io_debounce;

    typedef struct {
        string       tag;
        logic [33:0] exp;
    } sb_t;

    logic        HCLK;
    logic        HRESET;
    logic [17:0] SW_RAW;
    logic [4:0]  PB_RAW;
    logic [17:0] IO_Switch;
    logic [4:0]  IO_PB;
    logic [4:0]  PB_PRESS;
    logic [4:0]  PB_RELEASE;
    logic        SW_CHANGE;

    logic [33:0] w_obs;
    sb_t         sb_q[$];
    int          n_vec;
    int          n_miscompare;

    mipsfpga_io_debounce #(
        .DB_CYCLES(4),
        .CNT_W    (16)
    ) u_dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .SW_RAW    (SW_RAW),
        .PB_RAW    (PB_RAW),
        .IO_Switch (IO_Switch),
        .IO_PB     (IO_PB),
        .PB_PRESS  (PB_PRESS),
        .PB_RELEASE(PB_RELEASE),
        .SW_CHANGE (SW_CHANGE)
    );

    assign w_obs = {IO_Switch, IO_PB, PB_PRESS, PB_RELEASE, SW_CHANGE};

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic [33:0] mk(input logic [17:0] sw, input logic [4:0] pb,
                                       input logic [4:0] press, input logic [4:0] rel,
                                       input logic chg);
        return {sw, pb, press, rel, chg};
    endfunction

    task automatic push_n(input string tag, input logic [33:0] e, input int n);
        sb_t t;
        for (int k = 0; k < n; k++) begin
            t.tag = tag;
            t.exp = e;
            sb_q.push_back(t);
        end
    endtask

    task automatic check_pop();
        sb_t t;
        if (sb_q.size() == 0) begin
            n_miscompare++;
            $error("FAIL sb_empty: observed %h with no expected entry queued", w_obs);
        end else begin
            t = sb_q.pop_front();
            n_vec++;
            assert (w_obs === t.exp) else begin
                n_miscompare++;
                $error("FAIL %s: observed %h expected %h", t.tag, w_obs, t.exp);
            end
        end
    endtask

    task automatic run_edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge HCLK);
            #1;
            check_pop();
        end
    endtask

    initial begin
        n_vec        = 0;
        n_miscompare = 0;
        HRESET       = 1'b1;
        SW_RAW       = 18'h00000;
        PB_RAW       = 5'b00000;

        // Reset state, before any clock edge.
        #3;
        push_n("reset_state", mk(18'h0, 5'b00000, 5'b00000, 5'b00000, 1'b0), 1);
        check_pop();

        // Single pushbutton press, latency DB_CYCLES+2.
        @(negedge HCLK);
        HRESET = 1'b0;
        PB_RAW = 5'b00001;
        push_n("pb0_wait", mk(18'h0, 5'b00000, 5'b00000, 5'b00000, 1'b0), 5);
        push_n("pb0_upd",  mk(18'h0, 5'b00001, 5'b00001, 5'b00000, 1'b0), 1);
        push_n("pb0_hold", mk(18'h0, 5'b00001, 5'b00000, 5'b00000, 1'b0), 1);
        run_edges(7);

        // Three-cycle glitch on PB_RAW[2] is rejected.
        @(negedge HCLK);
        PB_RAW = 5'b00101;
        push_n("pb2_glitch", mk(18'h0, 5'b00001, 5'b00000, 5'b00000, 1'b0), 8);
        run_edges(3);
        @(negedge HCLK);
        PB_RAW = 5'b00001;
        run_edges(5);

        // Bring IO_PB[1] to 1.
        @(negedge HCLK);
        PB_RAW = 5'b00011;
        push_n("pb1_wait", mk(18'h0, 5'b00001, 5'b00000, 5'b00000, 1'b0), 5);
        push_n("pb1_upd",  mk(18'h0, 5'b00011, 5'b00010, 5'b00000, 1'b0), 1);
        push_n("pb1_hold", mk(18'h0, 5'b00011, 5'b00000, 5'b00000, 1'b0), 1);
        run_edges(7);

        // Release of PB[1] with a one-cycle bounce after two low cycles:
        // counting restarts, so the fall lands on edge 9.
        @(negedge HCLK);
        PB_RAW = 5'b00001;
        push_n("pb1_bounce", mk(18'h0, 5'b00011, 5'b00000, 5'b00000, 1'b0), 8);
        push_n("pb1_rel",    mk(18'h0, 5'b00001, 5'b00000, 5'b00010, 1'b0), 1);
        push_n("pb1_low",    mk(18'h0, 5'b00001, 5'b00000, 5'b00000, 1'b0), 1);
        run_edges(2);
        @(negedge HCLK);
        PB_RAW = 5'b00011;
        run_edges(1);
        @(negedge HCLK);
        PB_RAW = 5'b00001;
        run_edges(7);

        // All switches rise together: single SW_CHANGE pulse.
        @(negedge HCLK);
        SW_RAW = 18'h3FFFF;
        push_n("sw_all_wait", mk(18'h00000, 5'b00001, 5'b00000, 5'b00000, 1'b0), 5);
        push_n("sw_all_upd",  mk(18'h3FFFF, 5'b00001, 5'b00000, 5'b00000, 1'b1), 1);
        push_n("sw_all_hold", mk(18'h3FFFF, 5'b00001, 5'b00000, 5'b00000, 1'b0), 1);
        run_edges(7);

        // Switches down to 18'h00F0.
        @(negedge HCLK);
        SW_RAW = 18'h000F0;
        push_n("sw_f0_wait", mk(18'h3FFFF, 5'b00001, 5'b00000, 5'b00000, 1'b0), 5);
        push_n("sw_f0_upd",  mk(18'h000F0, 5'b00001, 5'b00000, 5'b00000, 1'b1), 1);
        push_n("sw_f0_hold", mk(18'h000F0, 5'b00001, 5'b00000, 5'b00000, 1'b0), 1);
        run_edges(7);

        // Start counting on PB[3], then reset asynchronously mid-count.
        @(negedge HCLK);
        PB_RAW = 5'b01001;
        push_n("pb3_count", mk(18'h000F0, 5'b00001, 5'b00000, 5'b00000, 1'b0), 3);
        run_edges(3);
        #2;
        HRESET = 1'b1;
        #1;
        push_n("rst_async", mk(18'h0, 5'b00000, 5'b00000, 5'b00000, 1'b0), 1);
        check_pop();
        push_n("rst_held", mk(18'h0, 5'b00000, 5'b00000, 5'b00000, 1'b0), 2);
        run_edges(2);

        // Inputs already high at release are treated as fresh transitions.
        @(negedge HCLK);
        HRESET = 1'b0;
        push_n("post_rst_wait", mk(18'h00000, 5'b00000, 5'b00000, 5'b00000, 1'b0), 5);
        push_n("post_rst_upd",  mk(18'h000F0, 5'b01001, 5'b01001, 5'b00000, 1'b1), 1);
        push_n("post_rst_hold", mk(18'h000F0, 5'b01001, 5'b00000, 5'b00000, 1'b0), 1);
        run_edges(7);

        // Clear everything: releases and switch change on the same edge.
        @(negedge HCLK);
        SW_RAW = 18'h00000;
        PB_RAW = 5'b00000;
        push_n("clr_wait", mk(18'h000F0, 5'b01001, 5'b00000, 5'b00000, 1'b0), 5);
        push_n("clr_upd",  mk(18'h00000, 5'b00000, 5'b00000, 5'b01001, 1'b1), 1);
        push_n("clr_hold", mk(18'h00000, 5'b00000, 5'b00000, 5'b00000, 1'b0), 1);
        run_edges(7);

        // Several pushbuttons and a switch together, all on the same edge.
        @(negedge HCLK);
        PB_RAW = 5'b10101;
        SW_RAW = 18'h00001;
        push_n("multi_wait", mk(18'h00000, 5'b00000, 5'b00000, 5'b00000, 1'b0), 5);
        push_n("multi_upd",  mk(18'h00001, 5'b10101, 5'b10101, 5'b00000, 1'b1), 1);
        push_n("multi_hold", mk(18'h00001, 5'b10101, 5'b00000, 5'b00000, 1'b0), 1);
        run_edges(7);

        // Every queued expectation must have been consumed.
        n_vec++;
        assert (sb_q.size() == 0) else begin
            n_miscompare++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule

// File: doc/mipsfpga_io_debounce.md
MIPSFPGA_IO_DEBOUNCE -- requirements
Module: mipsfpga_io_debounce

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, number of consecutive cycles a synchronized input must differ from its debounced value before that value updates (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16, per-bit counter width; SHALL hold DB_CYCLES-1.
REQ-003 HCLK  input  1  single clock; all state on rising edge.
REQ-004 HRESET  input  1  reset, asynchronous, active-high.
REQ-005 SW_RAW  input  18  raw slide-switch pins, asynchronous to HCLK.
REQ-006 PB_RAW  input  5  raw pushbutton pins, asynchronous to HCLK, 1 = pressed.
REQ-007 IO_Switch  output  18  debounced switches; feeds the GPIO switch read port.
REQ-008 IO_PB  output  5  debounced pushbuttons; feeds the GPIO pushbutton read port.
REQ-009 PB_PRESS  output  5  per-bit one-cycle pulse on a debounced 0->1 transition of IO_PB.
REQ-010 PB_RELEASE  output  5  per-bit one-cycle pulse on a debounced 1->0 transition of IO_PB.
REQ-011 SW_CHANGE  output  1  one-cycle pulse when any IO_Switch bit updates.
REQ-012 All outputs SHALL be driven directly from flops.

Function
REQ-013 Each of the 23 input bits SHALL pass through a two-flop synchronizer (sync1, sync2).
REQ-014 Each bit SHALL have an independent CNT_W-bit counter and a debounced state flop.
REQ-015 On each edge, if sync2 equals the debounced state, the counter SHALL clear to 0.
REQ-016 On each edge, if sync2 differs and counter < DB_CYCLES-1, the counter SHALL increment by 1.
REQ-017 On each edge, if sync2 differs and counter == DB_CYCLES-1, the debounced state SHALL take sync2 and the counter SHALL clear to 0.
REQ-018 Latency: a raw change, held stable and set up before edge 1, SHALL appear on IO_Switch/IO_PB at edge DB_CYCLES+2, not earlier.
REQ-019 A sync2 mismatch that ends before the count completes (glitch) SHALL clear the counter and leave the debounced state unchanged; a later mismatch SHALL restart counting from 0.
REQ-020 The counter SHALL never exceed DB_CYCLES-1; no wrap-around.
REQ-021 PB_PRESS[i] SHALL be 1 for exactly the cycle in which IO_PB[i] first reads 1 after an update, i.e. asserted on the same edge as the 0->1 update, and 0 otherwise.
REQ-022 PB_RELEASE[i] SHALL follow the same rule for a 1->0 update.
REQ-023 SW_CHANGE SHALL assert on the same edge as any IO_Switch update, for one cycle, regardless of how many bits update on that edge.
REQ-024 Bits SHALL be fully independent; simultaneous updates on several bits SHALL all take effect on their own completion edges.
REQ-025 PB_PRESS and PB_RELEASE SHALL never both be 1 for the same bit.

Reset
REQ-026 While HRESET=1: sync flops, counters, IO_Switch, IO_PB, PB_PRESS, PB_RELEASE, and SW_CHANGE SHALL all be 0, immediately and without a clock edge.
REQ-027 Reset asserted mid-count SHALL discard the count; after release, counting SHALL restart from 0 against debounced state 0.
REQ-028 Inputs already at 1 when reset releases SHALL be treated as real transitions: the update occurs at edge DB_CYCLES+2 after release, and the corresponding pulse SHALL fire.

Verification (DB_CYCLES=4)
REQ-029 PB_RAW[0] 0->1 before edge 1, held -> IO_PB[0]=1 and PB_PRESS[0]=1 at edge 6; PB_PRESS[0]=0 at edge 7; IO_PB[0]=0 at edges 1-5.
REQ-030 PB_RAW[2] high for 3 cycles then low -> IO_PB[2], PB_PRESS[2], and PB_RELEASE[2] stay 0 throughout.
REQ-031 SW_RAW 18'h00000->18'h3FFFF, held -> IO_Switch=18'h3FFFF at edge 6; SW_CHANGE high for exactly that one cycle.
REQ-032 IO_PB[1]=1, PB_RAW[1] 1->0, then bounce to 1 for one cycle after 2 low cycles, then 0 held -> IO_PB[1] falls only after 4 consecutive mismatched sync2 cycles following the bounce; PB_RELEASE[1] pulses once.
REQ-033 HRESET asserted asynchronously mid-count with IO_Switch=18'h00F0 -> all outputs 0 immediately; after release with SW_RAW=18'h00F0 held, IO_Switch=18'h00F0 and SW_CHANGE=1 at edge 6.
REQ-034 PB_RAW=5'b10101 and SW_RAW[0]=1 asserted together -> IO_PB=5'b10101, PB_PRESS=5'b10101, IO_Switch[0]=1, and SW_CHANGE=1, all on the same edge.
